// File: rtl/led_trail_pwm_if.sv
// Scanner-to-LED link: the scanner's advance strobe and LED index one way, and
// the PWM LED drive and sticky out-of-range flag back the other way.
interface led_trail_pwm_if #(
    parameter int NUM_LEDS = 10,
    parameter int POS_W    = 4
);
    logic                STEP;
    logic [POS_W-1:0]    POS;
    logic [NUM_LEDS-1:0] LEDR;
    logic                OOR_SEEN;

    modport master (output STEP, output POS, input LEDR, input OOR_SEEN);
    modport slave  (input STEP, input POS, output LEDR, output OOR_SEEN);
endinterface

// File: rtl/led_trail_pwm.sv
// led_trail_pwm: comet-tail LED driver downstream of the LED scanner.
// Every LED keeps a brightness level. The level is set to full when the scanner
// lands on that LED, and it decays by DECAY on each later advance. The level is
// rendered as free-running PWM on LEDR.
// Optional build macro LED_TRAIL_GAMMA_EN: the duty becomes (level*level) >> BRIGHT_W,
// which gives a perceptual fade. When the macro is undefined, the duty is the level itself.
module led_trail_pwm #(
    parameter int NUM_LEDS = 10,
    parameter int POS_W    = 4,
    parameter int BRIGHT_W = 4,
    parameter int DECAY    = 4,
    parameter int PWM_DIV  = 64
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    led_trail_pwm_if.slave   bus
);
    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [BRIGHT_W-1:0] MAX_L    = BRIGHT_W'((1 << BRIGHT_W) - 1);
    localparam logic [BRIGHT_W-1:0] DECAY_L  = BRIGHT_W'(DECAY);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PWM_DIV - 1);

    logic [NUM_LEDS-1:0][BRIGHT_W-1:0] level_q, level_d;
    logic [PRE_W-1:0]                  pre_q, pre_d;
    logic [BRIGHT_W-1:0]               pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LEDS-1:0]               ledr_q, ledr_d;
    logic                              oor_q, oor_d;
    logic                              pos_oor;

    // The decay saturates at zero, so a dim LED can never wrap back to bright.
    function automatic logic [BRIGHT_W-1:0] sat_decay(input logic [BRIGHT_W-1:0] lvl);
        return (lvl > DECAY_L) ? (lvl - DECAY_L) : '0;
    endfunction

    // Maps a level to its PWM duty. With gamma enabled, the full double-width
    // product is kept before the shift.
    function automatic logic [BRIGHT_W-1:0] to_duty(input logic [BRIGHT_W-1:0] lvl);
`ifdef LED_TRAIL_GAMMA_EN
        logic [2*BRIGHT_W-1:0] prod;
        prod = {{BRIGHT_W{1'b0}}, lvl} * {{BRIGHT_W{1'b0}}, lvl};
        return prod[2*BRIGHT_W-1:BRIGHT_W];
`else
        return lvl;
`endif
    endfunction

    assign pos_oor = (int'(bus.POS) >= NUM_LEDS);

    // Level update on each scanner advance. The hit LED is refreshed and all other LEDs decay.
    always_comb begin
        level_d = level_q;
        oor_d   = oor_q;
        if (bus.STEP) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (int'(bus.POS) == i) level_d[i] = MAX_L;
                else                    level_d[i] = sat_decay(level_q[i]);
            end
            if (pos_oor) oor_d = 1'b1;
        end
    end

    // Free-running PWM timebase. It is independent of STEP.
    always_comb begin
        pre_d     = pre_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q;
        if (pre_q == PRE_LAST) begin
            pre_d     = '0;
            pwm_cnt_d = pwm_cnt_q + 1'b1;
        end
    end

    // PWM compare. An LED is on while its duty exceeds the current slot.
    always_comb begin
        ledr_d = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            ledr_d[i] = (to_duty(level_q[i]) > pwm_cnt_q);
        end
    end

    // State registers. All state is cleared immediately by the asynchronous reset.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            level_q   <= '0;
            pre_q     <= '0;
            pwm_cnt_q <= '0;
            ledr_q    <= '0;
            oor_q     <= 1'b0;
        end else begin
            level_q   <= level_d;
            pre_q     <= pre_d;
            pwm_cnt_q <= pwm_cnt_d;
            ledr_q    <= ledr_d;
            oor_q     <= oor_d;
        end
    end

    assign bus.LEDR     = ledr_q;
    assign bus.OOR_SEEN = oor_q;
endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm at default parameters. A cycle-indexed reference model
// is compared every cycle, and a few literal duty and level values are checked.
module tb_led_trail_pwm;
    localparam int N    = 10;
    localparam int MAXV = 15;
    localparam int DEC  = 4;
    localparam int DIV  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    led_trail_pwm_if #(.NUM_LEDS(N), .POS_W(4)) bus ();

    led_trail_pwm dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    always #10 clk = ~clk;

    // Reference model. t counts edges since reset, so the PWM slot is (t/DIV) mod 16.
    int          t;
    int          lvl [N];
    logic [N-1:0] exp_ledr;
    logic        exp_oor;

    function automatic int duty_of(input int l);
`ifdef LED_TRAIL_GAMMA_EN
        return (l * l) / 16;
`else
        return l;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t        <= 0;
            exp_ledr <= '0;
            exp_oor  <= 1'b0;
            for (int i = 0; i < N; i++) lvl[i] <= 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                exp_ledr[i] <= (duty_of(lvl[i]) > ((t / DIV) % 16));
                if (bus.STEP) begin
                    if (int'(bus.POS) == i) lvl[i] <= MAXV;
                    else                    lvl[i] <= (lvl[i] > DEC) ? lvl[i] - DEC : 0;
                end
            end
            if (bus.STEP && int'(bus.POS) >= N) exp_oor <= 1'b1;
            t <= t + 1;
        end
    end

    // Cycle-by-cycle compare on the inactive edge.
    always @(negedge clk) begin
        checks++;
        if (bus.LEDR !== exp_ledr || bus.OOR_SEEN !== exp_oor) begin
            errors++;
            if (errors < 20)
                $display("FAIL cycle_cmp t=%0d LEDR got %b want %b OOR got %b want %b",
                         t, bus.LEDR, exp_ledr, bus.OOR_SEEN, exp_oor);
        end
    end

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic do_step(input int pos);
        bus.STEP = 1'b1;
        bus.POS  = 4'(pos);
        @(negedge clk);
        bus.STEP = 1'b0;
    endtask

    // Counts the high cycles of one LED over one full 1024-cycle PWM frame.
    task automatic count_frame(output int c0, output int c1, output int c5);
        c0 = 0; c1 = 0; c5 = 0;
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk);
            c0 += int'(bus.LEDR[0]);
            c1 += int'(bus.LEDR[1]);
            c5 += int'(bus.LEDR[5]);
        end
    endtask

    initial begin
        int c0, c1, c5, guard, hit15;
        bus.STEP = 1'b0;
        bus.POS  = '0;

        // Reset held while STEP pulses are present.
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bus.STEP = 1'b1; bus.POS = 4'(k);
            @(negedge clk);
        end
        bus.STEP = 1'b0;
        check_int("reset_ledr", int'(bus.LEDR), 0);
        check_int("reset_oor", int'(bus.OOR_SEEN), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Refresh and decay.
        do_step(3);
        check_int("lvl3_a", lvl[3], 15);
        do_step(4);
        check_int("lvl3_b", lvl[3], 11);
        check_int("lvl4_b", lvl[4], 15);
        do_step(5); check_int("lvl3_c", lvl[3], 7);
        do_step(6); check_int("lvl3_d", lvl[3], 3);
        do_step(7); check_int("lvl3_e", lvl[3], 0);
        do_step(8); check_int("lvl3_f", lvl[3], 0);

        // PWM duty: LED0=11, LED1=15, LED5 decayed to 0.
        do_step(0);
        do_step(1);
        repeat (2) @(negedge clk);
        count_frame(c0, c1, c5);
`ifdef LED_TRAIL_GAMMA_EN
        check_int("duty_l11", c0, 448);
        check_int("duty_l15", c1, 896);
`else
        check_int("duty_l11", c0, 704);
        check_int("duty_l15", c1, 960);
`endif
        check_int("duty_l0", c5, 0);

        // Out of range.
        do_step(9);
        do_step(12);
        check_int("oor_lvl9", lvl[9], 11);
        hit15 = 0;
        for (int i = 0; i < N; i++) if (lvl[i] == 15) hit15++;
        check_int("oor_no_refresh", hit15, 0);
        @(negedge clk);
        check_int("oor_set", int'(bus.OOR_SEEN), 1);
        do_step(1);
        @(negedge clk);
        check_int("oor_sticky", int'(bus.OOR_SEEN), 1);

        // Collision: the first STEP lands on a prescaler wrap edge, followed by a second back-to-back STEP.
        guard = 0;
        while ((t % DIV) != DIV - 1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_int("wrap_found", int'(guard < 200), 1);
        bus.STEP = 1'b1; bus.POS = 4'd2;
        @(negedge clk);
        bus.POS = 4'd3;
        @(negedge clk);
        bus.STEP = 1'b0;
        check_int("coll_lvl2", lvl[2], 11);
        check_int("coll_lvl3", lvl[3], 15);
        repeat (300) @(negedge clk);

        // Asynchronous reset applied mid-cycle.
        #3 rst_n = 1'b0;
        #1;
        check_int("async_ledr", int'(bus.LEDR), 0);
        check_int("async_oor", int'(bus.OOR_SEEN), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_step(5);
        check_int("post_rst_lvl5", lvl[5], 15);
        repeat (100) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
